game_timer: RTL and testbench



---
 rtl/game_timer_if.sv | 21 ++
 rtl/game_timer.sv | 118 +++++++++++
 tb/tb_game_timer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/game_timer_if.sv
// Signal bundle between the whack-a-mole round controller and the game/display side.
interface game_timer_if;
   logic       start;
   logic       abort;
   logic       EN;
   logic [3:0] secs_tens;
   logic [3:0] secs_ones;
   logic [1:0] state;
   logic       game_over;
   logic       warn;

   modport master (
      output start, abort,
      input  EN, secs_tens, secs_ones, state, game_over, warn
   );

   modport slave (
      input  start, abort,
      output EN, secs_tens, secs_ones, state, game_over, warn
   );
endinterface

// File: rtl/game_timer.sv
// Whack-a-mole round controller: BCD seconds countdown gating the game's EN input.
// Optional pause/resume on start is enabled by defining GAME_TIMER_PAUSE_EN.
module game_timer #(
   parameter int TICK_DIV  = 50000000,
   parameter int GAME_SECS = 60,
   parameter int WARN_SECS = 10
) (
   input logic         Clk,
   input logic         reset,
   game_timer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      OVER  = 2'b10,
      PAUSE = 2'b11
   } state_t;

   localparam int            PW          = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
   localparam logic [3:0]    RELOAD_TENS = 4'(GAME_SECS / 10);
   localparam logic [3:0]    RELOAD_ONES = 4'(GAME_SECS % 10);

   state_t        state_r;
   logic          start_q;
   logic [PW-1:0] presc;
   logic [3:0]    tens;
   logic [3:0]    ones;
   logic          en_r;
   logic          go_r;
   logic          rise;
   logic          tick;
   logic          pause_req;
   logic [6:0]    remaining;

   assign rise = bus.start & ~start_q;
   assign tick = (presc == PRESC_MAX);

`ifdef GAME_TIMER_PAUSE_EN
   assign pause_req = rise;
`else
   assign pause_req = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_r <= IDLE;
         start_q <= 1'b1;
         presc   <= '0;
         tens    <= RELOAD_TENS;
         ones    <= RELOAD_ONES;
         en_r    <= 1'b0;
         go_r    <= 1'b0;
      end else begin
         start_q <= bus.start;
         go_r    <= 1'b0;
         if (bus.abort) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            presc   <= '0;
            tens    <= RELOAD_TENS;
            ones    <= RELOAD_ONES;
         end else begin
            case (state_r)
               IDLE, OVER: begin
                  if (rise) begin
                     state_r <= RUN;
                     en_r    <= 1'b1;
                     presc   <= '0;
                     tens    <= RELOAD_TENS;
                     ones    <= RELOAD_ONES;
                  end
               end
               RUN: begin
                  // A pause request wins over a coincident tick: prescaler freezes as-is.
                  if (pause_req) begin
                     state_r <= PAUSE;
                     en_r    <= 1'b0;
                  end else if (tick) begin
                     presc <= '0;
                     if (tens == 4'd0 && ones == 4'd1) begin
                        state_r <= OVER;
                        en_r    <= 1'b0;
                        go_r    <= 1'b1;
                        ones    <= 4'd0;
                     end else if (ones == 4'd0) begin
                        ones <= 4'd9;
                        tens <= tens - 4'd1;
                     end else begin
                        ones <= ones - 4'd1;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               PAUSE: begin
                  if (rise) begin
                     state_r <= RUN;
                     en_r    <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign remaining = (7'(tens) * 7'd10) + 7'(ones);

   assign bus.EN        = en_r;
   assign bus.state     = state_r;
   assign bus.secs_tens = tens;
   assign bus.secs_ones = ones;
   assign bus.game_over = go_r;
   assign bus.warn      = ((state_r == RUN) || (state_r == PAUSE)) &&
                          (remaining <= 7'(WARN_SECS));

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with TICK_DIV=4, GAME_SECS=12, WARN_SECS=10.
module tb_game_timer;

   logic Clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;

   game_timer_if bus ();

   game_timer #(
      .TICK_DIV (4),
      .GAME_SECS(12),
      .WARN_SECS(10)
   ) dut (
      .Clk  (Clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 Clk = ~Clk;

   // Packed view: {state[1:0], EN, tens[3:0], ones[3:0], game_over, warn}
   typedef struct {
      string       name;
      logic        start;
      logic        abort;
      logic [12:0] exp;
   } vec_t;

   function automatic logic [12:0] pk(input logic [1:0] st, input logic en,
                                      input int t, input int o,
                                      input logic go, input logic w);
      return {st, en, 4'(t), 4'(o), go, w};
   endfunction

   // Expected outputs n edges after the edge that started a 12 s round.
   function automatic logic [12:0] exp_round(input int n);
      int rem;
      if (n < 48) begin
         rem = 12 - n / 4;
         return pk(2'b01, 1'b1, rem / 10, rem % 10, 1'b0, rem <= 10);
      end else if (n == 48) begin
         return pk(2'b10, 1'b0, 0, 0, 1'b1, 1'b0);
      end
      return pk(2'b10, 1'b0, 0, 0, 1'b0, 1'b0);
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [12:0] exp);
      logic [12:0] got;
      got = {bus.state, bus.EN, bus.secs_tens, bus.secs_ones, bus.game_over, bus.warn};
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got st=%b en=%b %0d/%0d go=%b warn=%b, expected st=%b en=%b %0d/%0d go=%b warn=%b",
                  name, got[12:11], got[10], got[9:6], got[5:2], got[1], got[0],
                  exp[12:11], exp[10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   vec_t tbl[9];

   initial begin
      tbl[0] = '{"start_held_after_reset", 1'b1, 1'b0, pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0)};
      tbl[1] = '{"idle_release",           1'b0, 1'b0, pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0)};
      tbl[2] = '{"abort_and_start",        1'b1, 1'b1, pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0)};
      tbl[3] = '{"idle_quiet",             1'b0, 1'b0, pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0)};
      tbl[4] = '{"start_edge",             1'b1, 1'b0, pk(2'b01, 1'b1, 1, 2, 1'b0, 1'b0)};
      tbl[5] = '{"run_presc1",             1'b1, 1'b0, pk(2'b01, 1'b1, 1, 2, 1'b0, 1'b0)};
      tbl[6] = '{"run_presc2",             1'b0, 1'b0, pk(2'b01, 1'b1, 1, 2, 1'b0, 1'b0)};
      tbl[7] = '{"run_presc3",             1'b0, 1'b0, pk(2'b01, 1'b1, 1, 2, 1'b0, 1'b0)};
      tbl[8] = '{"first_tick",             1'b0, 1'b0, pk(2'b01, 1'b1, 1, 1, 1'b0, 1'b0)};

      reset     = 1'b1;
      bus.start = 1'b1;
      bus.abort = 1'b0;
      step();
      step();
      check("reset_state", pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0));
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         bus.start = tbl[i].start;
         bus.abort = tbl[i].abort;
         step();
         check(tbl[i].name, tbl[i].exp);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;

      // Rest of the first round; with pause compiled out, a press at n=20 must be ignored.
      for (int n = 5; n <= 49; n++) begin
`ifndef GAME_TIMER_PAUSE_EN
         bus.start = (n == 20);
`endif
         step();
         check("round1", exp_round(n));
      end
      bus.start = 1'b0;

      bus.start = 1'b1;
      step();
      check("restart_from_over", exp_round(0));
      bus.start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         check("round2", exp_round(n));
      end
      bus.abort = 1'b1;
      step();
      check("abort_at_07", pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0));
      bus.abort = 1'b0;
      step();
      check("abort_no_pulse", pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0));

`ifdef GAME_TIMER_PAUSE_EN
      bus.start = 1'b1;
      step();
      check("pause_round_start", exp_round(0));
      bus.start = 1'b0;
      step();
      check("pause_presc1", exp_round(1));
      step();
      check("pause_presc2", exp_round(2));
      bus.start = 1'b1;
      step();
      check("pause_enter", pk(2'b11, 1'b0, 1, 2, 1'b0, 1'b0));
      bus.start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         check("pause_hold", pk(2'b11, 1'b0, 1, 2, 1'b0, 1'b0));
      end
      bus.start = 1'b1;
      step();
      check("resume", pk(2'b01, 1'b1, 1, 2, 1'b0, 1'b0));
      bus.start = 1'b0;
      step();
      check("resume_presc3", pk(2'b01, 1'b1, 1, 2, 1'b0, 1'b0));
      step();
      check("resume_first_tick", pk(2'b01, 1'b1, 1, 1, 1'b0, 1'b0));
      bus.start = 1'b1;
      step();
      check("pause_again", pk(2'b11, 1'b0, 1, 1, 1'b0, 1'b0));
      bus.start = 1'b0;
      bus.abort = 1'b1;
      step();
      check("abort_in_pause", pk(2'b00, 1'b0, 1, 2, 1'b0, 1'b0));
      bus.abort = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
